multiplier_seq_param: RTL and testbench

MULTIPLIER_SEQ_PARAM -- requirements
Module: multiplier_seq_param

---
 rtl/multiplier_seq_param.sv | 118 +++++++++++
 tb/tb_multiplier_seq_param.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/multiplier_seq_param.sv
// Sequential shift-add multiplier: WIDTH iterations per operation, optional
// two's-complement operands handled as sign/magnitude around an unsigned core.
module multiplier_seq_param #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 signed_mode,
   input  logic [WIDTH-1:0]     operand_a,
   input  logic [WIDTH-1:0]     operand_b,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   typedef enum logic {
      IDLE,
      CALC
   } state_t;

   state_t               state_q, state_d;
   logic [2*WIDTH:0]     acc_q, acc_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [WIDTH-1:0]     mcand_q, mcand_d;
   logic                 sign_q, sign_d;
   logic                 done_q, done_d;
   logic [2*WIDTH-1:0]   product_q, product_d;

   logic [WIDTH-1:0]     mag_a, mag_b;
   logic [WIDTH:0]       upper_sum;
   logic [2*WIDTH:0]     acc_step;
   logic [2*WIDTH-1:0]   result;
   logic                 last_iter;

   // Negating the most negative value wraps back to itself, which read as
   // unsigned is exactly its magnitude 2^(WIDTH-1).
   always_comb begin
      mag_a = operand_a;
      mag_b = operand_b;
      if (signed_mode && operand_a[WIDTH-1]) begin
         mag_a = (~operand_a) + WIDTH'(1);
      end
      if (signed_mode && operand_b[WIDTH-1]) begin
         mag_b = (~operand_b) + WIDTH'(1);
      end
   end

   always_comb begin
      upper_sum = acc_q[2*WIDTH:WIDTH] + (acc_q[0] ? {1'b0, mcand_q} : '0);
      acc_step  = {upper_sum, acc_q[WIDTH-1:0]} >> 1;
      result    = sign_q ? ((~acc_step[2*WIDTH-1:0]) + (2*WIDTH)'(1))
                         : acc_step[2*WIDTH-1:0];
      last_iter = (cnt_q == CNT_W'(WIDTH - 1));
   end

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      mcand_d   = mcand_q;
      sign_d    = sign_q;
      done_d    = 1'b0;
      product_d = product_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               // Multiplier magnitude rides in the low half and shifts out as
               // the partial product shifts in from the top.
               acc_d   = {{(WIDTH + 1){1'b0}}, mag_a};
               mcand_d = mag_b;
               sign_d  = signed_mode & (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]);
               cnt_d   = '0;
               state_d = CALC;
            end
         end
         CALC: begin
            acc_d = acc_step;
            cnt_d = cnt_q + CNT_W'(1);
            if (last_iter) begin
               product_d = result;
               done_d    = 1'b1;
               state_d   = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         acc_q     <= '0;
         cnt_q     <= '0;
         mcand_q   <= '0;
         sign_q    <= 1'b0;
         done_q    <= 1'b0;
         product_q <= '0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         mcand_q   <= mcand_d;
         sign_q    <= sign_d;
         done_q    <= done_d;
         product_q <= product_d;
      end
   end

   assign busy    = (state_q == CALC);
   assign done    = done_q;
   assign product = product_q;

endmodule

// File: tb/tb_multiplier_seq_param.sv
// Directed bench for multiplier_seq_param at WIDTH=8 and WIDTH=16; a done
// monitor pops expected product and completion cycle from per-DUT queues.
module tb_multiplier_seq_param;

   typedef struct {
      logic [31:0] prod;
      int unsigned cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   int unsigned cyc = 0;
   int checks = 0;
   int errors = 0;
   exp_t q8[$];
   exp_t q16[$];

   logic        start8 = 1'b0, sm8 = 1'b0;
   logic [7:0]  a8 = '0, b8 = '0;
   logic        busy8, done8;
   logic [15:0] product8;

   logic        start16 = 1'b0, sm16 = 1'b0;
   logic [15:0] a16 = '0, b16 = '0;
   logic        busy16, done16;
   logic [31:0] product16;

   multiplier_seq_param #(.WIDTH(8)) dut8 (
      .clock(clk), .reset(rst_n), .start(start8), .signed_mode(sm8),
      .operand_a(a8), .operand_b(b8), .busy(busy8), .done(done8),
      .product(product8)
   );

   multiplier_seq_param #(.WIDTH(16)) dut16 (
      .clock(clk), .reset(rst_n), .start(start16), .signed_mode(sm16),
      .operand_a(a16), .operand_b(b16), .busy(busy16), .done(done16),
      .product(product16)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] model8(input logic [7:0] a, input logic [7:0] b, input logic sm);
      logic signed [15:0] sa, sb;
      sa = sm ? 16'($signed(a)) : {8'b0, a};
      sb = sm ? 16'($signed(b)) : {8'b0, b};
      return 16'(sa * sb);
   endfunction

   function automatic logic [31:0] model16(input logic [15:0] a, input logic [15:0] b, input logic sm);
      logic signed [31:0] sa, sb;
      sa = sm ? 32'($signed(a)) : {16'b0, a};
      sb = sm ? 32'($signed(b)) : {16'b0, b};
      return 32'(sa * sb);
   endfunction

   // Drive one start pulse; returns in the first busy cycle.
   task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic sm, input logic [15:0] exp);
      a8 = a; b8 = b; sm8 = sm; start8 = 1'b1;
      q8.push_back('{prod: {16'b0, exp}, cyc: cyc + 9});
      step();
      start8 = 1'b0;
   endtask

   task automatic issue16(input logic [15:0] a, input logic [15:0] b, input logic sm, input logic [31:0] exp);
      a16 = a; b16 = b; sm16 = sm; start16 = 1'b1;
      q16.push_back('{prod: exp, cyc: cyc + 17});
      step();
      start16 = 1'b0;
   endtask

   task automatic wait_done8();
      for (int i = 0; i < 20 && !done8; i++) step();
      chk("done8_seen", {31'b0, done8}, 32'd1);
   endtask

   task automatic wait_done16();
      for (int i = 0; i < 30 && !done16; i++) step();
      chk("done16_seen", {31'b0, done16}, 32'd1);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (done8) begin
         chk("done8_expected", {31'b0, q8.size() != 0}, 32'd1);
         if (q8.size() != 0) begin
            e = q8.pop_front();
            chk("product8", {16'b0, product8}, e.prod);
            chk("done8_cycle", cyc, e.cyc);
         end
      end
      if (done16) begin
         chk("done16_expected", {31'b0, q16.size() != 0}, 32'd1);
         if (q16.size() != 0) begin
            e = q16.pop_front();
            chk("product16", product16, e.prod);
            chk("done16_cycle", cyc, e.cyc);
         end
      end
   end

   initial begin
      logic [7:0]  ra, rb;
      logic [15:0] ra16, rb16;
      logic        rs;

      #2 rst_n = 1'b0;
      #1;
      chk("rst_busy8", {31'b0, busy8}, 32'd0);
      chk("rst_done8", {31'b0, done8}, 32'd0);
      chk("rst_product8", {16'b0, product8}, 32'd0);
      chk("rst_product16", product16, 32'd0);
      step();
      step();
      rst_n = 1'b1;
      step();

      // 9*5 with per-cycle busy/done checks
      issue8(8'd9, 8'd5, 1'b0, 16'd45);
      for (int i = 1; i <= 8; i++) begin
         chk("t1_busy", {31'b0, busy8}, 32'd1);
         chk("t1_done_low", {31'b0, done8}, 32'd0);
         step();
      end
      chk("t1_done", {31'b0, done8}, 32'd1);
      chk("t1_busy_low", {31'b0, busy8}, 32'd0);

      // back-to-back on the done cycle; previous product must hold meanwhile
      issue8(8'd200, 8'd220, 1'b0, 16'd44000);
      for (int i = 1; i <= 8; i++) begin
         chk("t2_busy", {31'b0, busy8}, 32'd1);
         chk("t2_product_hold", {16'b0, product8}, 32'd45);
         step();
      end
      chk("t2_done", {31'b0, done8}, 32'd1);
      step();
      chk("t2_done_pulse", {31'b0, done8}, 32'd0);

      // signed boundaries
      issue8(8'hFD, 8'd7, 1'b1, 16'hFFEB);
      wait_done8();
      step();
      issue8(8'h80, 8'h80, 1'b1, 16'h4000);
      wait_done8();
      step();
      issue8(8'h80, 8'h7F, 1'b1, 16'hC080);
      wait_done8();
      step();

      // start while busy must be ignored; operand changes after capture too
      issue8(8'd9, 8'd5, 1'b0, 16'd45);
      step(); step(); step();
      a8 = 8'd255; b8 = 8'd255; sm8 = 1'b1; start8 = 1'b1;
      step();
      start8 = 1'b0; a8 = 8'd0; b8 = 8'd0;
      chk("t4_busy", {31'b0, busy8}, 32'd1);
      wait_done8();
      for (int i = 0; i < 12; i++) step();
      chk("t4_idle_after", {31'b0, busy8}, 32'd0);

      // async reset mid-operation, between clock edges
      a8 = 8'd200; b8 = 8'd220; sm8 = 1'b0; start8 = 1'b1;
      step();
      start8 = 1'b0;
      step(); step(); step(); step();
      #2 rst_n = 1'b0;
      #1;
      chk("t5_rst_busy", {31'b0, busy8}, 32'd0);
      chk("t5_rst_done", {31'b0, done8}, 32'd0);
      chk("t5_rst_product", {16'b0, product8}, 32'd0);
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 12; i++) step();
      chk("t5_no_restart", {31'b0, busy8}, 32'd0);
      issue8(8'd3, 8'd3, 1'b0, 16'd9);
      wait_done8();
      step();

      for (int i = 0; i < 6; i++) begin
         ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom);
         issue8(ra, rb, rs, model8(ra, rb, rs));
         wait_done8();
      end
      step();

      // WIDTH=16
      issue16(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001);
      for (int i = 1; i <= 16; i++) begin
         chk("w16_busy", {31'b0, busy16}, 32'd1);
         step();
      end
      chk("w16_done", {31'b0, done16}, 32'd1);
      issue16(16'd40000, 16'd50000, 1'b0, 32'd2000000000);
      wait_done16();
      step();
      chk("w16_done_pulse", {31'b0, done16}, 32'd0);
      issue16(16'h8000, 16'h8000, 1'b1, 32'h40000000);
      wait_done16();
      step();
      for (int i = 0; i < 4; i++) begin
         ra16 = 16'($urandom); rb16 = 16'($urandom);
         issue16(ra16, rb16, 1'b0, model16(ra16, rb16, 1'b0));
         wait_done16();
      end
      step();
      step();

      chk("q8_drained", q8.size(), 32'd0);
      chk("q16_drained", q16.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      errors++;
      $display("FAIL global_timeout: simulation did not complete");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "timeout");
   end

endmodule
